// File: rtl/uart_apb_regs_if.sv
// APB3 bus bundle between the system interconnect (master) and the UART
// register block (slave).
interface uart_apb_regs_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_regs.sv
// APB3 completer in front of the UART core: register file, baud divider,
// TX/RX handshake. Zero-wait-state transfers; PRDATA is registered.
// Optional feature: define UART_APB_PSLVERR_EN to report bad accesses on
// PSLVERR (unmapped offsets, writes to read-only registers, TXDATA writes
// while a byte is pending or in flight). Without it PSLVERR is always 0.
module uart_apb_regs #(
  parameter int          ADDR_WIDTH = 5,
  parameter logic [15:0] DIV_RESET  = 16'd5207
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  uart_apb_regs_if.slave    apb,
  output logic              tx_en,
  output logic              tx_rst,
  output logic              rx_en,
  output logic              rx_rst,
  output logic [7:0]        tx_data,
  output logic              BCLK,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic              rx_busy,
  input  logic              rx_done,
  input  logic              rx_error,
  input  logic [7:0]        rx_data
);

  // The state records the bus phase sampled at the last edge, so SETUP is
  // held while the requester is in its access cycle and ACCESS follows it.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_TXDATA = 3'd2;
  localparam logic [2:0] OFF_RXDATA = 3'd3;
  localparam logic [2:0] OFF_BAUD   = 3'd4;

  apb_state_t            state;
  logic [31:0]           prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic                  txe;
  logic                  rxe;
  logic                  tx_pend;
  logic                  err;
  logic                  tx_busy_q;
  logic [7:0]            tx_data_q;
  logic [15:0]           baud_div;
  logic [15:0]           baud_cnt;
  logic                  tx_rst_q;
  logic                  rx_rst_q;
  logic                  bclk_q;

  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            offset;
  logic                  setup_phase;
  logic                  commit;
  logic                  wr_commit;
  logic                  rd_commit;
  logic                  tx_blocked;
  logic                  ctrl_wr;
  logic                  txdata_wr;
  logic                  div_wr;
  logic                  status_rd;
  logic                  rxdata_rd;
  logic                  bad_access;
  logic [31:0]           rd_data;
  logic                  unused_bits;

  assign addr        = apb.PADDR;
  assign offset      = addr[4:2];
  assign setup_phase = apb.PSEL & ~apb.PENABLE;
  assign commit      = (state == SETUP) & apb.PSEL & apb.PENABLE;
  assign wr_commit   = commit & apb.PWRITE;
  assign rd_commit   = commit & ~apb.PWRITE;
  assign tx_blocked  = tx_pend | tx_busy;
  assign ctrl_wr     = wr_commit & (offset == OFF_CTRL);
  assign txdata_wr   = wr_commit & (offset == OFF_TXDATA) & ~tx_blocked;
  assign div_wr      = wr_commit & (offset == OFF_BAUD);
  assign status_rd   = rd_commit & (offset == OFF_STATUS);
  assign rxdata_rd   = rd_commit & (offset == OFF_RXDATA);
  assign unused_bits = ^{addr[1:0], apb.PWDATA[31:16]};

`ifdef UART_APB_PSLVERR_EN
  assign bad_access = (offset > OFF_BAUD)
                    | (apb.PWRITE & ((offset == OFF_STATUS) | (offset == OFF_RXDATA)))
                    | (apb.PWRITE & (offset == OFF_TXDATA) & tx_blocked);
`else
  assign bad_access = 1'b0;
`endif

  // Read multiplexer; unmapped offsets read as zero.
  always_comb begin
    rd_data = 32'd0;
    case (offset)
      OFF_CTRL:   rd_data = {30'd0, rxe, txe};
      OFF_STATUS: rd_data = {26'd0, tx_pend, err, rx_done, rx_busy, tx_done, tx_busy};
      OFF_TXDATA: rd_data = {24'd0, tx_data_q};
      OFF_RXDATA: rd_data = {24'd0, rx_data};
      OFF_BAUD:   rd_data = {16'd0, baud_div};
      default:    rd_data = 32'd0;
    endcase
  end

  // APB phase tracker with registered PREADY, PSLVERR and PRDATA.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'd0;
    end else begin
      case (state)
        IDLE, ACCESS: begin
          if (setup_phase) begin
            state     <= SETUP;
            pready_q  <= 1'b1;
            pslverr_q <= bad_access;
            if (!apb.PWRITE) prdata_q <= rd_data;
          end else begin
            state     <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end
        end
        SETUP: begin
          state     <= apb.PSEL ? ACCESS : IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  // Register file, TX pending flag, sticky error and one-cycle reset pulses.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      txe       <= 1'b0;
      rxe       <= 1'b0;
      tx_pend   <= 1'b0;
      err       <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_data_q <= 8'd0;
      baud_div  <= DIV_RESET;
      tx_rst_q  <= 1'b0;
      rx_rst_q  <= 1'b0;
    end else begin
      tx_busy_q <= tx_busy;
      tx_rst_q  <= ctrl_wr & apb.PWDATA[2];
      rx_rst_q  <= (ctrl_wr & apb.PWDATA[3]) | (rxdata_rd & rx_done);
      if (ctrl_wr) begin
        txe <= apb.PWDATA[0];
        rxe <= apb.PWDATA[1];
      end
      if (ctrl_wr && apb.PWDATA[2]) tx_pend <= 1'b0;
      else if (txdata_wr)           tx_pend <= 1'b1;
      else if (tx_busy && !tx_busy_q) tx_pend <= 1'b0;
      if (txdata_wr) tx_data_q <= apb.PWDATA[7:0];
      if (rx_error)       err <= 1'b1;
      else if (status_rd) err <= 1'b0;
      if (div_wr) baud_div <= apb.PWDATA[15:0];
    end
  end

  // Baud down-counter: BCLK for one cycle each time it passes zero.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_cnt <= DIV_RESET;
      bclk_q   <= 1'b0;
    end else if (div_wr) begin
      baud_cnt <= apb.PWDATA[15:0];
      bclk_q   <= 1'b0;
    end else if (!(txe | rxe)) begin
      baud_cnt <= baud_div;
      bclk_q   <= 1'b0;
    end else if (baud_cnt == 16'd0) begin
      baud_cnt <= baud_div;
      bclk_q   <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
      bclk_q   <= 1'b0;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign tx_en       = txe & (tx_pend | tx_busy);
  assign rx_en       = rxe;
  assign tx_rst      = tx_rst_q;
  assign rx_rst      = rx_rst_q;
  assign tx_data     = tx_data_q;
  assign BCLK        = bclk_q;

endmodule

// File: tb/tb_uart_apb_regs.sv
// Testbench for uart_apb_regs: directed scenarios plus a randomized access
// stream compared against a register-level behavioural model.
module tb_uart_apb_regs;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       tx_en, tx_rst, rx_en, rx_rst, BCLK;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done, rx_busy, rx_done, rx_error;
  logic [7:0] rx_data;

  int checks   = 0;
  int failures = 0;

`ifdef UART_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Behavioural model of the programmer-visible state.
  bit         m_txe, m_rxe, m_pend, m_err;
  logic [7:0] m_txdata;
  logic [15:0] m_div;

  uart_apb_regs_if #(.ADDR_WIDTH(5)) bus ();

  uart_apb_regs dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .apb      (bus.slave),
    .tx_en    (tx_en),
    .tx_rst   (tx_rst),
    .rx_en    (rx_en),
    .rx_rst   (rx_rst),
    .tx_data  (tx_data),
    .BCLK     (BCLK),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .rx_busy  (rx_busy),
    .rx_done  (rx_done),
    .rx_error (rx_error),
    .rx_data  (rx_data)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    m_txe = 0; m_rxe = 0; m_pend = 0; m_err = 0;
    m_txdata = 8'h00; m_div = 16'd5207;
  endtask

  task automatic setTxBusy(input logic v);
    if (!tx_busy && v) m_pend = 0;
    tx_busy = v;
  endtask

  // One complete APB transfer; samples PREADY in both phases, PRDATA/PSLVERR
  // in the access phase and the pulse outputs in the cycle after it.
  task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                               input logic err_pulse, output logic [31:0] rdata,
                               output logic [1:0] ready, output logic slverr,
                               output logic txr, output logic rxr);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
    #1 ready[1] = bus.PREADY;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    if (err_pulse) rx_error = 1'b1;
    rdata = bus.PRDATA; ready[0] = bus.PREADY; slverr = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; rx_error = 1'b0;
    txr = tx_rst; rxr = rx_rst;
  endtask

  // Predict a transfer from the register map rules, run it, compare.
  task automatic doAccess(input string tag, input logic wr, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic err_pulse);
    logic [2:0]  off;
    logic [31:0] exp_rd, rdata;
    logic        bad, exp_txr, exp_rxr, slverr, txr, rxr;
    logic [1:0]  ready;
    off = addr[4:2];
    bad = 0; exp_txr = 0; exp_rxr = 0;
    case (off)
      3'd0: exp_rd = {30'd0, m_rxe, m_txe};
      3'd1: exp_rd = {26'd0, m_pend, m_err, rx_done, rx_busy, tx_done, tx_busy};
      3'd2: exp_rd = {24'd0, m_txdata};
      3'd3: exp_rd = {24'd0, rx_data};
      3'd4: exp_rd = {16'd0, m_div};
      default: exp_rd = 32'd0;
    endcase
    if (off > 3'd4) bad = 1;
    if (wr) begin
      case (off)
        3'd0: begin
          m_txe = wdata[0]; m_rxe = wdata[1];
          exp_txr = wdata[2]; exp_rxr = wdata[3];
          if (wdata[2]) m_pend = 0;
        end
        3'd1, 3'd3: bad = 1;
        3'd2: begin
          if (m_pend || tx_busy) bad = 1;
          else begin m_txdata = wdata[7:0]; m_pend = 1; end
        end
        3'd4: m_div = wdata[15:0];
        default: ;
      endcase
    end else begin
      if (off == 3'd1) m_err = 0;
      if (off == 3'd3) exp_rxr = rx_done;
    end
    if (err_pulse) m_err = 1;
    applyStimulus(wr, addr, wdata, err_pulse, rdata, ready, slverr, txr, rxr);
    if (!wr) checkOutput({tag, "_prdata"}, rdata, exp_rd);
    checkOutput({tag, "_pready"}, {30'd0, ready}, 32'd1);
    checkOutput({tag, "_pslverr"}, {31'd0, slverr}, {31'd0, bad & ERR_EN});
    checkOutput({tag, "_pulses"}, {30'd0, txr, rxr}, {30'd0, exp_txr, exp_rxr});
    checkOutput({tag, "_outs"}, {22'd0, rx_en, tx_en, tx_data},
                {22'd0, m_rxe, m_txe & (m_pend | tx_busy), m_txdata});
  endtask

  initial begin
    logic [31:0] wd;
    logic [4:0]  ad;
    int          cyc, gap;
    logic        seen;

    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
    tx_busy = 0; tx_done = 0; rx_busy = 0; rx_done = 0; rx_error = 0; rx_data = 8'h00;
    PRESETn = 1'b0;
    resetModel();
    #12;
    checkOutput("rst_apb", {bus.PRDATA[29:0], bus.PREADY, bus.PSLVERR}, 32'd0);
    checkOutput("rst_uart", {19'd0, tx_en, rx_en, tx_rst, rx_rst, BCLK, tx_data}, 32'd0);
    @(negedge PCLK); PRESETn = 1'b1;

    // Reset register values and idle baud tick.
    doAccess("rst_ctrl", 0, 5'h00, 0, 0);
    doAccess("rst_status", 0, 5'h04, 0, 0);
    doAccess("rst_txdata", 0, 5'h08, 0, 0);
    doAccess("rst_baud", 0, 5'h10, 0, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(posedge PCLK); #1; seen |= BCLK; end
    checkOutput("bclk_idle", {31'd0, seen}, 32'd0);

    // Baud tick every BAUDDIV+1 cycles.
    doAccess("baud_wr", 1, 5'h10, 32'd3, 0);
    doAccess("ctrl_txe", 1, 5'h00, 32'h1, 0);
    cyc = 0;
    while (BCLK !== 1'b1 && cyc < 50) begin @(posedge PCLK); #1; cyc++; end
    checkOutput("bclk_first", {31'd0, BCLK}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge PCLK); #1;
      checkOutput("bclk_width", {31'd0, BCLK}, 32'd0);
      gap = 1;
      while (BCLK !== 1'b1 && gap < 50) begin @(posedge PCLK); #1; gap++; end
      checkOutput("bclk_period", gap, 32'd4);
    end

    // Transmit handshake.
    doAccess("tx_wr", 1, 5'h08, 32'hA5, 0);
    doAccess("tx_status", 0, 5'h04, 0, 0);
    doAccess("tx_busy_wr", 1, 5'h08, 32'h11, 0);
    setTxBusy(1);
    doAccess("tx_busy_status", 0, 5'h04, 0, 0);
    doAccess("tx_wr_busy", 1, 5'h08, 32'h5A, 0);
    setTxBusy(0); tx_done = 1; #1;
    checkOutput("tx_en_drop", {31'd0, tx_en}, 32'd0);
    doAccess("tx_done_status", 0, 5'h04, 0, 0);
    tx_done = 0;

    // Receive handshake.
    rx_done = 1; rx_data = 8'h3C;
    doAccess("rx_read", 0, 5'h0C, 0, 0);
    @(posedge PCLK); #1;
    checkOutput("rx_rst_low", {31'd0, rx_rst}, 32'd0);
    rx_done = 0;
    doAccess("rx_read_idle", 0, 5'h0C, 0, 0);

    // Sticky error: set wins over the clearing STATUS read.
    doAccess("err_set_read", 0, 5'h04, 0, 1);
    doAccess("err_sticky", 0, 5'h04, 0, 0);
    doAccess("err_cleared", 0, 5'h04, 0, 0);

    // Bad accesses have no effect.
    doAccess("bad_unmapped", 1, 5'h14, 32'hFFFF_FFFF, 0);
    doAccess("bad_status_wr", 1, 5'h04, 32'hFF, 0);
    doAccess("bad_unmapped_rd", 0, 5'h1C, 0, 0);
    doAccess("tx_wr2", 1, 5'h08, 32'h42, 0);
    setTxBusy(1);
    doAccess("bad_tx_busy", 1, 5'h08, 32'h99, 0);
    doAccess("bad_tx_rd", 0, 5'h08, 0, 0);
    setTxBusy(0);

    // Randomized access stream.
    for (int n = 0; n < 300; n++) begin
      tx_done = 1'($urandom); rx_busy = 1'($urandom);
      rx_done = 1'($urandom); rx_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) setTxBusy(1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        rx_error = 1'b1; m_err = 1;
        @(posedge PCLK); #1; rx_error = 1'b0;
      end
      ad = {3'($urandom_range(0, 7)), 2'($urandom)};
      wd = $urandom;
      doAccess("rand", 1'($urandom), ad, wd, 1'($urandom_range(0, 9) == 0));
    end

    // Reset in the middle of a transfer.
    setTxBusy(0);
    doAccess("pre_abort", 1, 5'h00, 32'h2, 0);
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 5'h00; bus.PWDATA = 32'h3;
    @(posedge PCLK); #1;
    bus.PENABLE = 1;
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("abort_outs", {21'd0, bus.PREADY, tx_en, rx_en, BCLK, tx_data}, 32'd0);
    bus.PSEL = 0; bus.PENABLE = 0;
    resetModel();
    @(negedge PCLK); PRESETn = 1'b1;
    doAccess("abort_ctrl", 0, 5'h00, 0, 0);
    doAccess("abort_baud", 0, 5'h10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_apb_regs.md
# uart_apb_regs

APB3 completer that fronts the UART core: decodes register accesses from the APB requester, drives the core's control strobes, TX byte and baud tick (BCLK), and returns the core's status and RX byte over PRDATA. It sits between the system APB interconnect and the UART core's control/status port. It holds the register file, baud divider and TX/RX handshake logic.

## Interface
- ADDR_WIDTH, 5, PADDR width; byte offsets 0x00-0x10 decoded on PADDR[4:2], PADDR[1:0] ignored.
- DIV_RESET, 16'd5207, BAUDDIV reset value (50 MHz / 9600 - 1).

- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1  APB controls.
- PADDR  in  ADDR_WIDTH  address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- tx_en, tx_rst, rx_en, rx_rst  out  1  UART core controls.
- tx_data  out  8  byte to transmit.
- BCLK  out  1  one-PCLK-wide baud tick.
- tx_busy, tx_done, rx_busy, rx_done, rx_error  in  1  UART core status.
- rx_data  in  8  received byte.

## Operation
- APB FSM: IDLE -> SETUP on PSEL & !PENABLE; SETUP -> ACCESS next cycle; ACCESS -> SETUP if PSEL & !PENABLE, else IDLE. PREADY = 1 only in ACCESS (zero wait states). Register write and read side effects commit on the ACCESS cycle; PRDATA loaded at end of SETUP, held until the next read.
- Registers:
  - 0x00 CTRL RW: [0] TXE, [1] RXE; [2] TXRST, [3] RXRST write-1 pulse, read 0.
  - 0x04 STATUS RO: [0] tx_busy, [1] tx_done, [2] rx_busy, [3] rx_done, [4] ERR (sticky), [5] TXPEND; upper bits 0. Reading clears ERR.
  - 0x08 TXDATA RW [7:0]: write loads tx_data, sets TXPEND.
  - 0x0C RXDATA RO [7:0]: returns rx_data; if rx_done=1, read issues a one-cycle rx_rst to rearm the receiver.
  - 0x10 BAUDDIV RW [15:0]: write reloads the baud counter.
- tx_en = TXE & (TXPEND | tx_busy). TXPEND clears on tx_busy 0->1 edge (registered previous value). TXDATA write while TXPEND or tx_busy is ignored.
- rx_en = RXE. tx_rst/rx_rst = CTRL pulse OR RXDATA-read pulse, one PCLK wide, registered; TXRST also clears TXPEND.
- ERR set on rx_error=1; set wins over simultaneous STATUS-read clear.
- Baud: 16-bit down-counter runs while TXE|RXE; at 0 asserts BCLK for one cycle and reloads BAUDDIV; period BAUDDIV+1 cycles; BAUDDIV=0 gives BCLK every cycle. Counter holds BAUDDIV, BCLK=0 while both enables are low.

## Timing
- Reset: PRDATA=0, PREADY=0, PSLVERR=0, CTRL=0, TXDATA=0, TXPEND=0, ERR=0, BAUDDIV=DIV_RESET, counter=DIV_RESET, tx_en=rx_en=tx_rst=rx_rst=BCLK=0, tx_data=0, FSM IDLE.
- Write latency: register value visible on outputs the cycle after ACCESS.
- Pulse outputs: high exactly the cycle after ACCESS, low the next.
- PSEL dropped during SETUP: FSM -> IDLE, no side effect.
- PRESETn asserted mid-transfer: transfer aborted, all state to reset values immediately.

## Configuration
- UART_APB_PSLVERR_EN defined: PSLVERR=1 in ACCESS for unmapped offset (0x14-0x1C), write to STATUS/RXDATA, or TXDATA write while TXPEND|tx_busy; erroring writes have no effect. PSLVERR 0 outside ACCESS.
- Undefined: PSLVERR tied 0; same accesses silently ignored; unmapped reads return 0.

## Test plan
- Reset, read all registers -> CTRL=0, STATUS=0, BAUDDIV=5207, PREADY only in ACCESS, BCLK idle.
- Write BAUDDIV=3, CTRL=0x1 -> BCLK single-cycle pulse every 4 PCLK.
- Write TXDATA=0xA5 with TXE=1 -> tx_data=0xA5, TXPEND=1, tx_en=1; TXPEND clears on tx_busy rise; tx_en drops after tx_done with tx_busy=0.
- Model rx_done=1, rx_data=0x3C; read RXDATA -> PRDATA=0x3C, rx_rst pulses one cycle; read again with rx_done=0 -> no rx_rst.
- Pulse rx_error while reading STATUS -> ERR remains 1; next STATUS read returns [4]=1 then clears.
- With UART_APB_PSLVERR_EN: write PADDR=0x14 and TXDATA during tx_busy -> PSLVERR=1, registers unchanged; without macro -> PSLVERR=0, same no-effect.
